mul_share_ctrl: RTL and testbench

- Controller that shares one 16x16 combinational array multiplier between two requesters.
- Arbitrates requests round-robin, registers the winning operands onto the multiplier inputs, and waits a programmable number of cycles for the ripple array to settle (multicycle path).
- Captures the 32-bit product and returns it with a one-cycle acknowledge to the owning requester.
- Sits between the two client datapaths and a single multiplier instance; the multiplier is external, driven through oMulA/oMulB and read back on iMulO.

---
 rtl/mul_share_ctrl.sv | 100 ++++++++++
 tb/tb_mul_share_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one external WIDTH x WIDTH combinational multiplier
// between two requesters. Round-robin arbitration, registered operands,
// a programmable settle window for the ripple array, and a one-cycle ack
// to the requester that owns the returned product.
module mul_share_ctrl #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2      // settle cycles, 1..255
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iReq0,
    input  logic [WIDTH-1:0]   iA0,
    input  logic [WIDTH-1:0]   iB0,
    input  logic               iReq1,
    input  logic [WIDTH-1:0]   iA1,
    input  logic [WIDTH-1:0]   iB1,
    output logic               oAck0,
    output logic               oAck1,
    output logic [2*WIDTH-1:0] oResult,
    output logic               oOwner,
    output logic               oBusy,
    output logic [WIDTH-1:0]   oMulA,
    output logic [WIDTH-1:0]   oMulB,
    input  logic [2*WIDTH-1:0] iMulO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LAT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       last_served;   // requester that completed most recently
    logic       any_req;
    logic       grant1;

    // Winner selection: a lone request wins; on contention the requester
    // that was not served last wins.
    assign any_req = iReq0 | iReq1;
    assign grant1  = iReq1 & (~iReq0 | ~last_served);

    // Controller FSM with all outputs registered.
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // blocking assignments would make the result depend on statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: reset is sampled on the clock edge, so it needs no
            // separate sensitivity entry and aborts an operation cleanly.
            state       <= IDLE;
            cnt         <= 8'd0;
            last_served <= 1'b1;   // makes requester 0 win the first contention
            oAck0       <= 1'b0;
            oAck1       <= 1'b0;
            oResult     <= '0;
            oOwner      <= 1'b0;
            oBusy       <= 1'b0;
            oMulA       <= '0;
            oMulB       <= '0;
        end else begin
            oAck0 <= 1'b0;
            oAck1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        oOwner <= grant1;
                        oMulA  <= grant1 ? iA1 : iA0;
                        oMulB  <= grant1 ? iB1 : iB0;
                        cnt    <= CNT_LOAD;
                        oBusy  <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 8'd0) begin
                        oResult <= iMulO;
                        oAck0   <= ~oOwner;
                        oAck1   <= oOwner;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    last_served <= oOwner;
                    oBusy       <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl. The shared multiplier is modelled as an
// ideal combinational product; expected values are hand-computed constants.
module tb_mul_share_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---- main instance, LAT = 2 ----
    logic        req0 = 0, req1 = 0;
    logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic        ack0, ack1, owner, busy;
    logic [31:0] result, mulo;
    logic [15:0] mula, mulb;
    assign mulo = 32'(mula) * 32'(mulb);

    mul_share_ctrl #(.WIDTH(16), .LAT(2)) dut (
        .Clock(clk), .Reset(rst),
        .iReq0(req0), .iA0(a0), .iB0(b0),
        .iReq1(req1), .iA1(a1), .iB1(b1),
        .oAck0(ack0), .oAck1(ack1), .oResult(result), .oOwner(owner),
        .oBusy(busy), .oMulA(mula), .oMulB(mulb), .iMulO(mulo)
    );

    // ---- LAT = 1 instance ----
    logic        l1_req = 0;
    logic [15:0] l1_a = 0, l1_b = 0;
    logic        l1_ack0, l1_ack1, l1_owner, l1_busy;
    logic [31:0] l1_result, l1_mulo;
    logic [15:0] l1_mula, l1_mulb;
    assign l1_mulo = 32'(l1_mula) * 32'(l1_mulb);

    mul_share_ctrl #(.WIDTH(16), .LAT(1)) dut_l1 (
        .Clock(clk), .Reset(rst),
        .iReq0(l1_req), .iA0(l1_a), .iB0(l1_b),
        .iReq1(1'b0), .iA1(16'd0), .iB1(16'd0),
        .oAck0(l1_ack0), .oAck1(l1_ack1), .oResult(l1_result), .oOwner(l1_owner),
        .oBusy(l1_busy), .oMulA(l1_mula), .oMulB(l1_mulb), .iMulO(l1_mulo)
    );

    // ---- LAT = 5 instance ----
    logic        l5_req = 0;
    logic [15:0] l5_a = 0, l5_b = 0;
    logic        l5_ack0, l5_ack1, l5_owner, l5_busy;
    logic [31:0] l5_result, l5_mulo;
    logic [15:0] l5_mula, l5_mulb;
    assign l5_mulo = 32'(l5_mula) * 32'(l5_mulb);

    mul_share_ctrl #(.WIDTH(16), .LAT(5)) dut_l5 (
        .Clock(clk), .Reset(rst),
        .iReq0(l5_req), .iA0(l5_a), .iB0(l5_b),
        .iReq1(1'b0), .iA1(16'd0), .iB1(16'd0),
        .oAck0(l5_ack0), .oAck1(l5_ack1), .oResult(l5_result), .oOwner(l5_owner),
        .oBusy(l5_busy), .oMulA(l5_mula), .oMulB(l5_mulb), .iMulO(l5_mulo)
    );

    // Advance one cycle; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        tick(2);
        check("rst_ack0",   32'(ack0),  32'd0);
        check("rst_ack1",   32'(ack1),  32'd0);
        check("rst_result", result,     32'd0);
        check("rst_owner",  32'(owner), 32'd0);
        check("rst_busy",   32'(busy),  32'd0);
        check("rst_mula",   32'(mula),  32'd0);
        check("rst_mulb",   32'(mulb),  32'd0);
        rst = 1'b0;
        tick();

        // ---------------- basic 3x5 on req0 ----------------
        req0 = 1; a0 = 3; b0 = 5;              // cycle 0
        tick();                                // cycle 1
        check("basic_mula_c1", 32'(mula), 32'd3);
        check("basic_mulb_c1", 32'(mulb), 32'd5);
        check("basic_busy_c1", 32'(busy), 32'd1);
        check("basic_ack0_c1", 32'(ack0), 32'd0);
        tick();                                // cycle 2
        check("basic_busy_c2", 32'(busy), 32'd1);
        check("basic_ack0_c2", 32'(ack0), 32'd0);
        tick();                                // cycle 3
        check("basic_ack0_c3",   32'(ack0),  32'd1);
        check("basic_ack1_c3",   32'(ack1),  32'd0);
        check("basic_result_c3", result,     32'h0000_000F);
        check("basic_owner_c3",  32'(owner), 32'd0);
        check("basic_busy_c3",   32'(busy),  32'd1);
        req0 = 0;
        tick();                                // cycle 4
        check("basic_ack0_c4",   32'(ack0), 32'd0);
        check("basic_busy_c4",   32'(busy), 32'd0);
        check("basic_hold_res",  result,    32'h0000_000F);
        check("basic_hold_mula", 32'(mula), 32'd3);

        // ---------------- full scale on req1 ----------------
        req1 = 1; a1 = 16'hFFFF; b1 = 16'hFFFF;
        tick(3);
        check("full_ack1",   32'(ack1),  32'd1);
        check("full_ack0",   32'(ack0),  32'd0);
        check("full_result", result,     32'hFFFE_0001);
        check("full_owner",  32'(owner), 32'd1);
        req1 = 0;
        tick();

        // ---------------- contention right after reset ----------------
        rst = 1; tick(); rst = 0;
        req0 = 1; a0 = 3; b0 = 4;
        req1 = 1; a1 = 7; b1 = 9;              // cycle 0
        tick(3);                               // cycle 3
        check("cont_ack0_c3",   32'(ack0), 32'd1);
        check("cont_ack1_c3",   32'(ack1), 32'd0);
        check("cont_result_c3", result,    32'd12);
        req0 = 0;
        tick();                                // cycle 4: req1 granted at end
        check("cont_busy_c4", 32'(busy), 32'd0);
        tick();                                // cycle 5
        check("cont_mula_c5",  32'(mula),  32'd7);
        check("cont_owner_c5", 32'(owner), 32'd1);
        tick();                                // cycle 6
        check("cont_ack1_c6", 32'(ack1), 32'd0);
        tick();                                // cycle 7
        check("cont_ack1_c7",   32'(ack1), 32'd1);
        check("cont_ack0_c7",   32'(ack0), 32'd0);
        check("cont_result_c7", result,    32'd63);
        req1 = 0;
        tick();

        // ---------------- fairness: both held for 6 operations ----------------
        // Requester 1 was served last, so requester 0 wins first.
        req0 = 1; a0 = 10; b0 = 11;
        req1 = 1; a1 = 20; b1 = 30;
        for (int i = 0; i < 6; i++) begin
            tick(2);
            check($sformatf("fair%0d_noack0_early", i), 32'(ack0), 32'd0);
            check($sformatf("fair%0d_noack1_early", i), 32'(ack1), 32'd0);
            tick();
            check($sformatf("fair%0d_ack0", i),   32'(ack0), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("fair%0d_ack1", i),   32'(ack1), (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("fair%0d_result", i), result,    (i % 2 == 0) ? 32'd110 : 32'd600);
            if (i == 5) begin
                req0 = 0;
                req1 = 0;
            end
            tick();
        end
        check("fair_idle_after", 32'(busy), 32'd0);

        // ---------------- reset mid-operation ----------------
        req0 = 1; a0 = 5; b0 = 6;              // cycle 0
        tick(2);                               // cycle 2
        rst = 1;
        tick();
        check("midrst_busy",   32'(busy),  32'd0);
        check("midrst_result", result,     32'd0);
        check("midrst_ack0",   32'(ack0),  32'd0);
        check("midrst_mula",   32'(mula),  32'd0);
        check("midrst_owner",  32'(owner), 32'd0);
        rst = 0;                               // req0 still high: fresh op, cycle 0
        tick();
        check("midrst_ack0_c1", 32'(ack0), 32'd0);
        tick();
        check("midrst_ack0_c2", 32'(ack0), 32'd0);
        tick();
        check("midrst_ack0_c3",   32'(ack0), 32'd1);
        check("midrst_result_c3", result,    32'd30);
        req0 = 0;
        tick();

        // ---------------- LAT = 1 ----------------
        l1_req = 1; l1_a = 2; l1_b = 2;        // cycle 0
        tick();
        check("lat1_ack_c1", 32'(l1_ack0), 32'd0);
        tick();
        check("lat1_ack_c2",    32'(l1_ack0), 32'd1);
        check("lat1_result_c2", l1_result,    32'd4);
        l1_req = 0;
        tick();
        check("lat1_ack_c3", 32'(l1_ack0), 32'd0);

        // ---------------- LAT = 5 ----------------
        l5_req = 1; l5_a = 3; l5_b = 7;        // cycle 0
        tick(5);
        check("lat5_ack_c5", 32'(l5_ack0), 32'd0);
        check("lat5_busy_c5", 32'(l5_busy), 32'd1);
        tick();
        check("lat5_ack_c6",    32'(l5_ack0), 32'd1);
        check("lat5_result_c6", l5_result,    32'd21);
        l5_req = 0;
        tick();
        check("lat5_ack_c7", 32'(l5_ack0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
